// File: rtl/soc_boot_loader_pkg.sv
// Shared types and helpers for the boot loader: FSM state encoding, default write command,
// and the byte stride between consecutive image words.
package soc_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_SRC,
        ST_WRITE,
        ST_NEXT,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [7:0] WR_CMD_WRITE = 8'h02;

    function automatic int unsigned addr_step(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/soc_boot_loader_if.sv
// Boot loader signal bundle: start/status, image source, memory write port, core control.
// Checksum signals exist only when SOC_BOOT_LOADER_CHECKSUM_EN is defined.
interface soc_boot_loader_if #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_WORDS = 32
);
    localparam int IW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int WCW = $clog2(MAX_WORDS + 1);

    logic           start_i;
    logic           src_req_o;
    logic [IW-1:0]  src_idx_o;
    logic           src_valid_i;
    logic [DW-1:0]  src_data_i;
    logic           wr_valid_o;
    logic           wr_ready_i;
    logic [7:0]     wr_cmd_o;
    logic [AW-1:0]  wr_addr_o;
    logic [DW-1:0]  wr_data_o;
    logic           fetch_enable_o;
    logic           en_ifetch_o;
    logic [DW-1:0]  gpio_i;
    logic           busy_o;
    logic           done_o;
    logic           pass_o;
    logic [WCW-1:0] words_o;
`ifdef SOC_BOOT_LOADER_CHECKSUM_EN
    logic [DW-1:0]  checksum_i;
    logic [DW-1:0]  checksum_o;
`endif

    modport master (
`ifdef SOC_BOOT_LOADER_CHECKSUM_EN
        input  checksum_i,
        output checksum_o,
`endif
        input  start_i, src_valid_i, src_data_i, wr_ready_i, gpio_i,
        output src_req_o, src_idx_o, wr_valid_o, wr_cmd_o, wr_addr_o, wr_data_o,
        output fetch_enable_o, en_ifetch_o, busy_o, done_o, pass_o, words_o
    );

    modport slave (
`ifdef SOC_BOOT_LOADER_CHECKSUM_EN
        output checksum_i,
        input  checksum_o,
`endif
        output start_i, src_valid_i, src_data_i, wr_ready_i, gpio_i,
        input  src_req_o, src_idx_o, wr_valid_o, wr_cmd_o, wr_addr_o, wr_data_o,
        input  fetch_enable_o, en_ifetch_o, busy_o, done_o, pass_o, words_o
    );

endinterface

// File: rtl/soc_boot_loader_timer.sv
// Loadable down-counter for the run window; expire_o flags the last enabled cycle.
module soc_boot_loader_timer #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (en_i && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire_o = en_i && (cnt == W'(1));

endmodule

// File: rtl/soc_boot_loader.sv
// Boot sequencer: loads an image word by word into core memory, then runs the core and checks GPIO.
// Build option SOC_BOOT_LOADER_CHECKSUM_EN adds a write checksum that must also match to pass.
module soc_boot_loader
    import soc_boot_loader_pkg::*;
#(
    parameter int             DW         = 32,
    parameter int             AW         = 32,
    parameter int             MAX_WORDS  = 32,
    parameter logic [AW-1:0]  BASE_ADDR  = 'h80,
    parameter logic [DW-1:0]  END_WORD   = 'h00000fff,
    parameter int             RUN_CYCLES = 400,
    parameter logic [DW-1:0]  EXPECT     = 987,
    parameter logic [7:0]     WR_CMD     = WR_CMD_WRITE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    soc_boot_loader_if.master bus
);
    // state     | meaning
    // ST_IDLE   | waiting for start_i
    // ST_REQ    | one-cycle read request for word idx
    // ST_WAIT_SRC | waiting for src_valid_i
    // ST_WRITE  | write request held until wr_ready_i
    // ST_NEXT   | sentinel / last-word decision; first run cycle when stopping
    // ST_RUN    | fetch enabled, counting down the run window
    // ST_DONE   | result held until next start_i

    localparam int IW   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int WCW  = $clog2(MAX_WORDS + 1);
    localparam int RW   = $clog2(RUN_CYCLES + 1);
    localparam int STEP = addr_step(DW);

    state_e         state, state_nxt;
    logic [IW-1:0]  idx;
    logic [DW-1:0]  data_q;
    logic [WCW-1:0] words_q;
    logic           pass_q;
    logic           start_ok, hs, stop, run_win, expire, result_ok;

    assign start_ok = bus.start_i && ((state == ST_IDLE) || (state == ST_DONE));
    assign hs       = (state == ST_WRITE) && bus.wr_ready_i;
    assign stop     = (data_q == END_WORD) || (idx == IW'(MAX_WORDS - 1));
    // The run window opens in NEXT so fetch starts the cycle right after the last handshake.
    assign run_win  = (state == ST_RUN) || ((state == ST_NEXT) && stop);

    soc_boot_loader_timer #(.W(RW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (hs),
        .load_val_i (RW'(RUN_CYCLES)),
        .en_i       (run_win),
        .expire_o   (expire)
    );

`ifdef SOC_BOOT_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum_q;
    assign bus.checksum_o = checksum_q;
    assign result_ok = (bus.gpio_i == EXPECT) && (checksum_q == bus.checksum_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (hs) begin
            checksum_q <= checksum_q + data_q;
        end
    end
`else
    assign result_ok = (bus.gpio_i == EXPECT);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            idx     <= '0;
            data_q  <= '0;
            words_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                idx     <= '0;
                words_q <= '0;
                pass_q  <= 1'b0;
            end
            if ((state == ST_WAIT_SRC) && bus.src_valid_i) begin
                data_q <= bus.src_data_i;
            end
            if (hs) begin
                words_q <= words_q + WCW'(1);
            end
            if ((state == ST_NEXT) && !stop) begin
                idx <= idx + IW'(1);
            end
            if (run_win && expire) begin
                pass_q <= result_ok;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (bus.start_i) state_nxt = ST_REQ;
            ST_REQ:           state_nxt = ST_WAIT_SRC;
            ST_WAIT_SRC:      if (bus.src_valid_i) state_nxt = ST_WRITE;
            ST_WRITE:         if (bus.wr_ready_i) state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (!stop)       state_nxt = ST_REQ;
                else if (expire) state_nxt = ST_DONE;
                else             state_nxt = ST_RUN;
            end
            ST_RUN:           if (expire) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    assign bus.src_req_o      = (state == ST_REQ);
    assign bus.src_idx_o      = idx;
    assign bus.wr_valid_o     = (state == ST_WRITE);
    assign bus.wr_cmd_o       = (state == ST_WRITE) ? WR_CMD : 8'h00;
    assign bus.wr_addr_o      = (state == ST_WRITE) ? (BASE_ADDR + AW'(idx) * AW'(STEP)) : '0;
    assign bus.wr_data_o      = (state == ST_WRITE) ? data_q : '0;
    assign bus.fetch_enable_o = run_win;
    assign bus.en_ifetch_o    = run_win;
    assign bus.busy_o         = (state != ST_IDLE) && (state != ST_DONE);
    assign bus.done_o         = (state == ST_DONE);
    assign bus.pass_o         = pass_q;
    assign bus.words_o        = words_q;

endmodule

// File: tb/tb_soc_boot_loader.sv
// Directed bench for soc_boot_loader: source/write/fetch monitors plus a linear check sequence.
module tb_soc_boot_loader;
    import soc_boot_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    soc_boot_loader_if #(.DW(32), .AW(32), .MAX_WORDS(32)) bus ();

    soc_boot_loader dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [31:0] img [32];
    int          lat = 1;

    // write / fetch monitor state
    logic [31:0] wa [64];
    logic [31:0] wd [64];
    int          nwr;
    int          n88;
    logic [7:0]  cmd_seen;
    int          cyc = 0;
    int          last_hs;
    int          first_fetch;
    int          fetch_cnt;
    logic        en_bad;
    logic        stall_all = 1'b0;
    logic        stall_en  = 1'b0;
    int          stall_cnt;
    logic        stall_bad;
    logic [31:0] st_addr, st_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({bus.src_req_o, bus.src_idx_o, bus.wr_valid_o, bus.wr_cmd_o, bus.wr_addr_o,
                     bus.wr_data_o, bus.fetch_enable_o, bus.en_ifetch_o, bus.busy_o,
                     bus.done_o, bus.pass_o, bus.words_o});
    endfunction

    task automatic clear_mon();
        nwr = 0; n88 = 0; cmd_seen = 8'h00; last_hs = -1; first_fetch = -1;
        fetch_cnt = 0; en_bad = 1'b0; stall_cnt = 0; stall_bad = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk); bus.start_i = 1'b1;
        @(negedge clk); bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!bus.done_o && n < budget) begin
            @(negedge clk); n++;
        end
        check(tag, 128'(bus.done_o), 128'(1));
    endtask

    // image source: answers each request after lat cycles with a one-cycle valid
    initial begin
        int i;
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.src_req_o) begin
                i = int'(bus.src_idx_o);
                repeat (lat) @(negedge clk);
                bus.src_valid_i = 1'b1;
                bus.src_data_i  = img[i];
                @(negedge clk);
                bus.src_valid_i = 1'b0;
            end
        end
    end

    // ready driver and write/fetch recorder
    initial begin
        bus.wr_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (stall_all) begin
                bus.wr_ready_i = 1'b0;
            end else if (stall_en && bus.wr_valid_o && bus.wr_addr_o == 32'h88 && stall_cnt < 7) begin
                if (stall_cnt == 0) begin
                    st_addr = bus.wr_addr_o;
                    st_data = bus.wr_data_o;
                end else if (bus.wr_addr_o !== st_addr || bus.wr_data_o !== st_data) begin
                    stall_bad = 1'b1;
                end
                bus.wr_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                bus.wr_ready_i = 1'b1;
            end
            if (bus.wr_valid_o && bus.wr_ready_i) begin
                if (stall_en && bus.wr_addr_o == 32'h88 &&
                    (bus.wr_addr_o !== st_addr || bus.wr_data_o !== st_data)) stall_bad = 1'b1;
                if (nwr < 64) begin
                    wa[nwr] = bus.wr_addr_o;
                    wd[nwr] = bus.wr_data_o;
                end
                if (bus.wr_addr_o == 32'h88) n88++;
                nwr++;
                cmd_seen = bus.wr_cmd_o;
                last_hs  = cyc;
            end
            if (bus.fetch_enable_o) begin
                fetch_cnt++;
                if (first_fetch < 0) first_fetch = cyc;
            end
            if (bus.fetch_enable_o !== bus.en_ifetch_o) en_bad = 1'b1;
        end
    end

    initial begin
        int n;
        bus.start_i = 1'b0;
        bus.gpio_i  = 32'd987;
`ifdef SOC_BOOT_LOADER_CHECKSUM_EN
        bus.checksum_i = 32'h0;
`endif
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 128'(0));
        rst = 1'b0;

`ifndef SOC_BOOT_LOADER_CHECKSUM_EN
        // 1: five-word image with sentinel, start pulse during RUN must be ignored
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44; img[4] = 32'hfff;
        lat = 3; bus.gpio_i = 32'd987;
        clear_mon();
        kick();
        check("busy_after_start", 128'(bus.busy_o), 128'(1));
        n = 0;
        while (fetch_cnt < 100 && n < 3000) begin @(negedge clk); n++; end
        kick();
        wait_done("t1_done", 3000);
        check("t1_nwr", 128'(nwr), 128'(5));
        check("t1_addr0", 128'(wa[0]), 128'(32'h80));
        check("t1_addr4", 128'(wa[4]), 128'(32'h90));
        check("t1_data2", 128'(wd[2]), 128'(32'h33));
        check("t1_data4", 128'(wd[4]), 128'(32'hfff));
        check("t1_cmd", 128'(cmd_seen), 128'(8'h02));
        check("t1_words", 128'(bus.words_o), 128'(5));
        check("t1_fetch_cycles", 128'(fetch_cnt), 128'(400));
        check("t1_fetch_start", 128'(first_fetch - last_hs), 128'(1));
        check("t1_en_ifetch_eq", 128'(en_bad), 128'(0));
        check("t1_pass", 128'(bus.pass_o), 128'(1));
        check("t1_busy_done", 128'(bus.busy_o), 128'(0));
        @(negedge clk);
        check("t1_fetch_dropped", 128'(bus.fetch_enable_o), 128'(0));

        // 2: same image, wrong gpio; done drops on restart from DONE
        bus.gpio_i = 32'd986; lat = 1;
        clear_mon();
        kick();
        check("t2_done_cleared", 128'(bus.done_o), 128'(0));
        wait_done("t2_done", 3000);
        check("t2_pass", 128'(bus.pass_o), 128'(0));
        check("t2_words", 128'(bus.words_o), 128'(5));

        // 3: full 32-word image without sentinel
        for (int i = 0; i < 32; i++) img[i] = 32'(i * 3 + 1);
        bus.gpio_i = 32'd987; lat = 1;
        clear_mon();
        kick();
        wait_done("t3_done", 4000);
        check("t3_nwr", 128'(nwr), 128'(32));
        check("t3_last_addr", 128'(wa[31]), 128'(32'hfc));
        check("t3_last_data", 128'(wd[31]), 128'(32'd94));
        check("t3_words", 128'(bus.words_o), 128'(32));
        check("t3_fetch_cycles", 128'(fetch_cnt), 128'(400));
        check("t3_pass", 128'(bus.pass_o), 128'(1));

        // 4: ready held low 7 cycles on word 2
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44; img[4] = 32'hfff;
        lat = 2;
        clear_mon();
        stall_en = 1'b1;
        kick();
        wait_done("t4_done", 3000);
        stall_en = 1'b0;
        check("t4_stall_cycles", 128'(stall_cnt), 128'(7));
        check("t4_stable", 128'(stall_bad), 128'(0));
        check("t4_no_dup", 128'(n88), 128'(1));
        check("t4_nwr", 128'(nwr), 128'(5));
        check("t4_data3", 128'(wd[3]), 128'(32'h44));

        // 5a: reset while a write is pending
        clear_mon();
        stall_all = 1'b1;
        kick();
        n = 0;
        while (!bus.wr_valid_o && n < 100) begin @(negedge clk); n++; end
        check("t5_reached_write", 128'(bus.wr_valid_o), 128'(1));
        rst = 1'b1; #1;
        check("t5_write_reset_outs", outs(), 128'(0));
        check("t5_no_write", 128'(nwr), 128'(0));
        @(negedge clk); stall_all = 1'b0; rst = 1'b0;

        // 5b: reset during run window
        clear_mon();
        kick();
        n = 0;
        while (fetch_cnt < 50 && n < 3000) begin @(negedge clk); n++; end
        check("t5_reached_run", 128'(bus.fetch_enable_o), 128'(1));
        rst = 1'b1; #1;
        check("t5_run_reset_outs", outs(), 128'(0));
        @(negedge clk); rst = 1'b0;

        // 5c: reboot starts from word 0
        repeat (lat + 3) @(negedge clk);
        clear_mon();
        kick();
        wait_done("t5_reboot_done", 3000);
        check("t5_reboot_addr0", 128'(wa[0]), 128'(32'h80));
        check("t5_reboot_nwr", 128'(nwr), 128'(5));
        check("t5_reboot_pass", 128'(bus.pass_o), 128'(1));
`else
        // checksum build: image {1,2,0xfff}
        img[0] = 32'h1; img[1] = 32'h2; img[2] = 32'hfff;
        lat = 1; bus.gpio_i = 32'd987; bus.checksum_i = 32'h1002;
        check("ck_reset", 128'(bus.checksum_o), 128'(0));
        clear_mon();
        kick();
        wait_done("ck_done", 3000);
        check("ck_sum", 128'(bus.checksum_o), 128'(32'h1002));
        check("ck_nwr", 128'(nwr), 128'(3));
        check("ck_words", 128'(bus.words_o), 128'(3));
        check("ck_pass", 128'(bus.pass_o), 128'(1));
        bus.checksum_i = 32'h1003;
        clear_mon();
        kick();
        check("ck_cleared", 128'(bus.checksum_o), 128'(0));
        wait_done("ck_done2", 3000);
        check("ck_sum2", 128'(bus.checksum_o), 128'(32'h1002));
        check("ck_pass_mismatch", 128'(bus.pass_o), 128'(0));
        bus.checksum_i = 32'h1002; bus.gpio_i = 32'd986;
        clear_mon();
        kick();
        wait_done("ck_done3", 3000);
        check("ck_pass_gpio_bad", 128'(bus.pass_o), 128'(0));
        rst = 1'b1; #1;
        check("ck_rst_sum", 128'(bus.checksum_o), 128'(0));
        check("ck_rst_outs", outs(), 128'(0));
        @(negedge clk); rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
